playback_audio: RTL and testbench

- Playback-side counterpart of the mic capture/decimation path.
- Accepts signed 16-bit samples at 24 kHz through a valid/ready handshake and buffers them in a small FIFO.
- Interpolates 2x to 48 kHz (linear midpoint), applies a volume shift, and drives a PWM DAC pin.
- Paced by the same 48 kHz one-cycle trigger that qualifies mic data in the audio_clk domain.

---
 rtl/playback_audio.sv | 158 +++++++++++++++
 tb/tb_playback_audio.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_audio.sv
// ---------------------------------------------------------------------------
// playback_audio
//   Playback path: 24 kHz signed samples enter a small FIFO through a
//   valid/ready handshake. Each 48 kHz dac_trigger advances a two-phase
//   interpolator that emits linear midpoints. The result is attenuated by an
//   arithmetic right shift and also drives a PWM DAC pin.
//
// Ports
//   audio_clk        sole clock
//   rst_in           asynchronous active-low reset
//   dac_trigger      one-cycle 48 kHz tick (each asserted cycle is a tick)
//   sample_valid     upstream offers sample_in
//   sample_in        signed 24 kHz sample
//   sample_ready     FIFO not full (registered from occupancy)
//   vol_shift        arithmetic right-shift attenuation, 0..15
//   audio_out        signed 48 kHz interpolated, attenuated sample
//   audio_out_valid  one-cycle pulse, the cycle after a trigger
//   pwm_out          PWM DAC drive
//   underrun_count   saturating count of phase-0 ticks that found the FIFO empty
// ---------------------------------------------------------------------------
module playback_audio #(
  parameter int FIFO_DEPTH = 4,
  parameter int PWM_BITS   = 8
) (
  input  logic        audio_clk,
  input  logic        rst_in,
  input  logic        dac_trigger,
  input  logic        sample_valid,
  input  logic [15:0] sample_in,
  output logic        sample_ready,
  input  logic [3:0]  vol_shift,
  output logic [15:0] audio_out,
  output logic        audio_out_valid,
  output logic        pwm_out,
  output logic [7:0]  underrun_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]       FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [PWM_BITS-1:0] DUTY_MID   = PWM_BITS'(1) << (PWM_BITS - 1);

  // FIFO storage and pointers
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;

  // Interpolator. Only the latest sample (cur) feeds any output, so the
  // older neighbour is not kept as separate state.
  logic               phase_q, phase_d;
  logic signed [15:0] cur_q, cur_d;
  logic [7:0]         under_q, under_d;

  // Output stage and PWM
  logic signed [15:0]  audio_q, audio_d;
  logic                valid_q, valid_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;

  // Combinational intermediates
  logic               wr_en;
  logic               tick0;
  logic               pop;
  logic signed [15:0] head;
  logic signed [16:0] sum;
  logic signed [15:0] y;
  logic [15:0]        offset;

  always_comb begin
    wr_en = sample_valid && ready_q;
    tick0 = dac_trigger && !phase_q;
    // A pop only sees entries written on earlier cycles: no write bypass.
    pop   = tick0 && (count_q != '0);
    head  = mem_q[rd_ptr_q];

    // 17-bit sum so the midpoint of two full-scale samples cannot overflow.
    sum = {cur_q[15], cur_q} + {head[15], head};
    y   = pop ? 16'(sum >>> 1) : cur_q;

    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = sample_in;
    end
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(pop);
    ready_d  = (count_d != FULL_COUNT);

    phase_d = phase_q ^ dac_trigger;
    cur_d   = pop ? head : cur_q;

    under_d = under_q;
    if (tick0 && !pop && (under_q != 8'hFF)) begin
      under_d = under_q + 8'd1;
    end

    audio_d = audio_q;
    if (dac_trigger) begin
      audio_d = y >>> vol_shift;
    end
    valid_d = dac_trigger;

    // Duty is reloaded only as the counter wraps, so a period in progress
    // is never disturbed by a new audio_out value.
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    offset    = {~audio_q[15], audio_q[14:0]};
    duty_d    = duty_q;
    if (pwm_cnt_q == '1) begin
      duty_d = PWM_BITS'(offset >> (16 - PWM_BITS));
    end
    pwm_d = (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      phase_q   <= 1'b0;
      cur_q     <= '0;
      under_q   <= '0;
      audio_q   <= '0;
      valid_q   <= 1'b0;
      pwm_cnt_q <= '0;
      duty_q    <= DUTY_MID;
      pwm_q     <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      phase_q   <= phase_d;
      cur_q     <= cur_d;
      under_q   <= under_d;
      audio_q   <= audio_d;
      valid_q   <= valid_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
    end
  end

  assign sample_ready    = ready_q;
  assign audio_out       = audio_q;
  assign audio_out_valid = valid_q;
  assign pwm_out         = pwm_q;
  assign underrun_count  = under_q;

endmodule

// File: tb/tb_playback_audio.sv
// ---------------------------------------------------------------------------
// tb_playback_audio
//   Directed bench for playback_audio: a table of push/trigger/reset records
//   with hand-computed outputs, plus hand-written sequences for asynchronous
//   reset, FIFO backpressure, underrun saturation and PWM duty behaviour.
// ---------------------------------------------------------------------------
module tb_playback_audio;

  logic        audio_clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        dac_trigger = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_ready;
  logic [3:0]  vol_shift = '0;
  logic [15:0] audio_out;
  logic        audio_out_valid;
  logic        pwm_out;
  logic [7:0]  underrun_count;

  always #5 audio_clk = ~audio_clk;

  playback_audio #(.FIFO_DEPTH(4), .PWM_BITS(8)) dut (
    .audio_clk       (audio_clk),
    .rst_in          (rst_in),
    .dac_trigger     (dac_trigger),
    .sample_valid    (sample_valid),
    .sample_in       (sample_in),
    .sample_ready    (sample_ready),
    .vol_shift       (vol_shift),
    .audio_out       (audio_out),
    .audio_out_valid (audio_out_valid),
    .pwm_out         (pwm_out),
    .underrun_count  (underrun_count)
  );

  // Clock edges since reset release; matches the free-running PWM counter.
  int cyc;
  always @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  typedef enum {OP_PUSH, OP_TRIG, OP_RST} op_e;
  typedef struct {
    op_e        op;
    int         data;
    logic [3:0] vol;
    int         exp_audio;
    int         exp_under;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(op_e op, int data, logic [3:0] vol, int ea, int eu);
    vec_t v;
    v.op = op; v.data = data; v.vol = vol; v.exp_audio = ea; v.exp_under = eu;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge audio_clk);
    #1;
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    dac_trigger  = 1'b0;
    rst_in       = 1'b0;
    repeat (2) @(posedge audio_clk);
    #2 rst_in = 1'b1;
  endtask

  task automatic push(input int v, input string nm);
    chk({nm, " ready"}, {31'd0, sample_ready}, 1);
    sample_valid = 1'b1;
    sample_in    = 16'(v);
    tick();
    sample_valid = 1'b0;
    $display("push %0d", v);
  endtask

  task automatic trig(input logic [3:0] vs, input int ea, input int eu, input string nm);
    vol_shift   = vs;
    dac_trigger = 1'b1;
    tick();
    dac_trigger = 1'b0;
    chk({nm, " valid"}, {31'd0, audio_out_valid}, 1);
    chk({nm, " audio"}, $signed(audio_out), ea);
    chk({nm, " under"}, {24'd0, underrun_count}, eu);
    $display("trig vol=%0d audio_out=%0d underrun=%0d", vs, $signed(audio_out), underrun_count);
    tick();
    chk({nm, " valid low"}, {31'd0, audio_out_valid}, 0);
  endtask

  // Advance at least one cycle, then until cyc lands on residue m.
  task automatic wait_mod(input int m, input string nm);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (((cyc % 256) != m) && (k < 600));
    if (k >= 600) chk({nm, " wait bound"}, k, 0);
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (pwm_out) hi++;
    end
  endtask

  initial begin
    int hi;
    int k;
    int full_exp[9];

    // Steady interpolation
    add(OP_RST, 0, 0, 0, 0);
    add(OP_PUSH, 1000, 0, 0, 0);
    add(OP_PUSH, 2000, 0, 0, 0);
    add(OP_PUSH, 3000, 0, 0, 0);
    add(OP_TRIG, 0, 0, 500, 0);
    add(OP_TRIG, 0, 0, 1000, 0);
    add(OP_TRIG, 0, 0, 1500, 0);
    add(OP_TRIG, 0, 0, 2000, 0);
    add(OP_TRIG, 0, 0, 2500, 0);
    add(OP_TRIG, 0, 0, 3000, 0);
    // Extremes and attenuation
    add(OP_PUSH, 32767, 0, 0, 0);
    add(OP_TRIG, 0, 0, 17883, 0);
    add(OP_TRIG, 0, 0, 32767, 0);
    add(OP_PUSH, 32767, 0, 0, 0);
    add(OP_TRIG, 0, 0, 32767, 0);
    add(OP_TRIG, 0, 0, 32767, 0);
    add(OP_PUSH, -32768, 0, 0, 0);
    add(OP_TRIG, 0, 0, -1, 0);
    add(OP_TRIG, 0, 0, -32768, 0);
    add(OP_PUSH, -1000, 0, 0, 0);
    add(OP_TRIG, 0, 0, -16884, 0);
    add(OP_TRIG, 0, 4, -63, 0);
    add(OP_PUSH, -1, 0, 0, 0);
    add(OP_TRIG, 0, 3, -63, 0);
    add(OP_TRIG, 0, 5, -1, 0);
    // Underrun
    add(OP_RST, 0, 0, 0, 0);
    add(OP_PUSH, 100, 0, 0, 0);
    add(OP_TRIG, 0, 0, 50, 0);
    add(OP_TRIG, 0, 0, 100, 0);
    add(OP_TRIG, 0, 0, 100, 1);
    add(OP_TRIG, 0, 0, 100, 1);
    add(OP_TRIG, 0, 0, 100, 2);
    add(OP_TRIG, 0, 0, 100, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_RST: begin
          do_reset();
          chk($sformatf("v%0d rst audio", i), $signed(audio_out), 0);
          chk($sformatf("v%0d rst under", i), {24'd0, underrun_count}, 0);
          chk($sformatf("v%0d rst ready", i), {31'd0, sample_ready}, 1);
          $display("reset");
        end
        OP_PUSH: push(tbl[i].data, $sformatf("v%0d", i));
        default: trig(tbl[i].vol, tbl[i].exp_audio, tbl[i].exp_under, $sformatf("v%0d", i));
      endcase
    end

    // Asynchronous reset with 3 entries buffered and phase 1
    do_reset();
    push(10, "ar");
    push(20, "ar");
    push(30, "ar");
    push(40, "ar");
    trig(0, 5, 0, "ar pre");
    #3 rst_in = 1'b0;
    #1;
    chk("ar during audio", $signed(audio_out), 0);
    chk("ar during valid", {31'd0, audio_out_valid}, 0);
    chk("ar during ready", {31'd0, sample_ready}, 1);
    chk("ar during under", {24'd0, underrun_count}, 0);
    chk("ar during pwm", {31'd0, pwm_out}, 0);
    $display("async reset asserted");
    @(posedge audio_clk);
    #2 rst_in = 1'b1;
    chk("ar release ready", {31'd0, sample_ready}, 1);
    trig(0, 0, 1, "ar post0");
    trig(0, 0, 1, "ar post1");

    // FIFO full / backpressure
    do_reset();
    sample_valid = 1'b1;
    for (int v = 11; v <= 14; v++) begin
      sample_in = 16'(v);
      tick();
    end
    chk("full ready after 4", {31'd0, sample_ready}, 0);
    sample_in = 16'd15;
    repeat (2) tick();
    chk("full ready held", {31'd0, sample_ready}, 0);
    dac_trigger = 1'b1;
    tick();
    dac_trigger = 1'b0;
    chk("full pop audio", $signed(audio_out), 5);
    chk("full ready after pop", {31'd0, sample_ready}, 1);
    tick();
    sample_valid = 1'b0;
    chk("full ready after 5th", {31'd0, sample_ready}, 0);
    $display("backpressure: 5th sample offered");
    full_exp = '{11, 11, 12, 12, 13, 13, 14, 14, 15};
    for (int i = 0; i < 9; i++) begin
      trig(0, full_exp[i], 0, $sformatf("drain%0d", i));
    end

    // Underrun saturation with back-to-back triggers
    dac_trigger = 1'b1;
    repeat (508) tick();
    dac_trigger = 1'b0;
    chk("sat 254", {24'd0, underrun_count}, 254);
    dac_trigger = 1'b1;
    repeat (92) tick();
    dac_trigger = 1'b0;
    chk("sat 255", {24'd0, underrun_count}, 255);
    chk("sat hold audio", $signed(audio_out), 15);
    $display("saturation: underrun=%0d", underrun_count);

    // PWM duty
    do_reset();
    count_high(256, hi);
    chk("pwm mid", hi, 128);
    $display("pwm audio 0: %0d high", hi);
    push(-32768, "pwm");
    trig(0, -16384, 0, "pwm lo0");
    trig(0, -32768, 0, "pwm lo1");
    wait_mod(0, "pwm a");
    wait_mod(5, "pwm b");
    count_high(256, hi);
    chk("pwm min", hi, 0);
    $display("pwm audio -32768: %0d high", hi);
    wait_mod(100, "pwm c");
    push(32767, "pwm");
    trig(0, -1, 0, "pwm hi0");
    trig(0, 32767, 0, "pwm hi1");
    // Remainder of the current period must keep the old (zero) duty.
    hi = 0;
    k = 0;
    while (((cyc % 256) != 250) && (k < 300)) begin
      tick();
      k++;
      if (pwm_out) hi++;
    end
    chk("pwm no mid-period change", hi, 0);
    wait_mod(5, "pwm d");
    count_high(256, hi);
    chk("pwm max", hi, 255);
    $display("pwm audio 32767: %0d high", hi);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
